// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
//
// Purpose:
//   Groups the byte-request handshake and the per-cycle frame outputs of the
//   UART transmit frame controller into one bundle.
//
// Signals:
//   p_data     [DATA_WIDTH]  parallel word to transmit (source -> controller)
//   data_valid [1]           p_data valid, honoured only while idle
//   par_en     [1]           1 = insert a parity bit after the data bits
//   par_typ    [1]           0 = even parity, 1 = odd parity
//   mux_sel    [2]           frame-bit select: 00 start, 01 data, 10 parity,
//                            11 stop/idle (controller -> TX mux)
//   ser_data   [1]           current data bit, LSB first
//   par_bit    [1]           parity of the latched word
//   busy       [1]           frame in progress; new requests are ignored
//
// Modports:
//   master  the data source / TX mux side
//   slave   the frame controller
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  mux_sel,
    input  ser_data,
    input  par_bit,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output mux_sel,
    output ser_data,
    output par_bit,
    output busy
  );

endinterface : uart_tx_ctrl_if

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   Frame controller and serializer for the UART transmitter, sitting directly
//   upstream of the registered TX output mux. A parallel word accepted on
//   data_valid is walked through start, data (LSB first), optional parity and
//   stop, one frame bit per clk cycle (clk is the baud-rate clock).
//
// Ports:
//   clk   baud-rate clock, rising edge active
//   rst   asynchronous, active-low reset
//   bus   uart_tx_ctrl_if.slave: p_data, data_valid, par_en, par_typ in;
//         mux_sel, ser_data, par_bit, busy out
//
// Parameters:
//   DATA_WIDTH  data bits per frame, 5..9
//
// Build options:
//   UART_TX_STOP2_EN  when defined, the stop bit lasts two cycles (extra STOP2
//                     state); when undefined, a single stop cycle and no extra
//                     state is built.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_STOP2_EN
    , STOP2
`endif
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  par_en_reg;
  logic                  par_bit_reg;
  logic [1:0]            mux_sel_reg;
  logic                  busy_reg;

  // mux_sel and busy are loaded together with the state they belong to, so
  // they are pure functions of the state register and never follow inputs
  // combinationally. par_typ only matters at acceptance; its effect is
  // captured in par_bit_reg, which stays stable for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      mux_sel_reg <= SEL_STOP;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          mux_sel_reg <= SEL_STOP;
          busy_reg    <= 1'b0;
          if (bus.data_valid) begin
            shift_reg   <= bus.p_data;
            par_en_reg  <= bus.par_en;
            par_bit_reg <= (^bus.p_data) ^ bus.par_typ;
            state_reg   <= START;
            mux_sel_reg <= SEL_START;
            busy_reg    <= 1'b1;
          end
        end

        START: begin
          cnt_reg     <= '0;
          state_reg   <= DATA;
          mux_sel_reg <= SEL_DATA;
          busy_reg    <= 1'b1;
        end

        DATA: begin
          // shift_reg[0] is on ser_data during this cycle; advance to the
          // next bit for the following one.
          shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
          cnt_reg   <= cnt_reg + CNT_W'(1);
          busy_reg  <= 1'b1;
          if (cnt_reg == LAST_BIT) begin
            if (par_en_reg) begin
              state_reg   <= PARITY;
              mux_sel_reg <= SEL_PARITY;
            end else begin
              state_reg   <= STOP;
              mux_sel_reg <= SEL_STOP;
            end
          end else begin
            mux_sel_reg <= SEL_DATA;
          end
        end

        PARITY: begin
          state_reg   <= STOP;
          mux_sel_reg <= SEL_STOP;
          busy_reg    <= 1'b1;
        end

        STOP: begin
          mux_sel_reg <= SEL_STOP;
`ifdef UART_TX_STOP2_EN
          state_reg   <= STOP2;
          busy_reg    <= 1'b1;
`else
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
`endif
        end

`ifdef UART_TX_STOP2_EN
        STOP2: begin
          state_reg   <= IDLE;
          mux_sel_reg <= SEL_STOP;
          busy_reg    <= 1'b0;
        end
`endif

        default: begin
          state_reg   <= IDLE;
          mux_sel_reg <= SEL_STOP;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel  = mux_sel_reg;
  assign bus.busy     = busy_reg;
  assign bus.ser_data = shift_reg[0];
  assign bus.par_bit  = par_bit_reg;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Directed stimulus pushes the expected per-cycle frame contents into a
// queue when a word is offered; an independent monitor pops one entry for
// every cycle the controller reports busy and compares the outputs.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0] mux;
    logic       chk_ser;
    logic       ser;
    logic       par;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // monitor bookkeeping
  int idle_run  = 100;
  int last_gap  = -1;
  int cur_len   = 0;
  int last_len  = -1;
  bit prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int frame_len(input logic pe);
    int n;
    n = 2 + DW + (pe ? 1 : 0);
`ifdef UART_TX_STOP2_EN
    n++;
`endif
    return n;
  endfunction

  task automatic push_frame(input logic [DW-1:0] d, input logic pe,
                            input logic pt);
    logic par;
    par = (^d) ^ pt;
    exp_q.push_back({2'b00, 1'b0, 1'b0, par});
    for (int i = 0; i < DW; i++)
      exp_q.push_back({2'b01, 1'b1, d[i], par});
    if (pe)
      exp_q.push_back({2'b10, 1'b0, 1'b0, par});
    exp_q.push_back({2'b11, 1'b0, 1'b0, par});
`ifdef UART_TX_STOP2_EN
    exp_q.push_back({2'b11, 1'b0, 1'b0, par});
`endif
  endtask

  // Monitor: one scoreboard entry per busy cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_busy = 1'b0;
      cur_len   = 0;
      idle_run  = 100;
    end else begin
      if (bus.busy === 1'b1) begin
        if (!prev_busy) begin
          last_gap = idle_run;
          cur_len  = 0;
        end
        idle_run = 0;
        cur_len++;
        check("sb_entry_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mux_sel", 32'(bus.mux_sel), 32'(e.mux));
          check("par_bit", 32'(bus.par_bit), 32'(e.par));
          if (e.chk_ser)
            check("ser_data", 32'(bus.ser_data), 32'(e.ser));
        end
      end else begin
        if (prev_busy)
          last_len = cur_len;
        idle_run++;
      end
      prev_busy = bus.busy;
    end
  end

  // Offer one word for a single cycle; DUT must be idle.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    push_frame(d, pe, pt);
    $display("TX p_data=%02h par_en=%0d par_typ=%0d", d, pe, pt);
    @(posedge clk);
    @(negedge clk);
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_mux_start", 32'(bus.mux_sel), 32'd0);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (bus.busy === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int exp_len);
    wait_level(1'b0, "busy_drop_timeout");
    check("frame_len", 32'(last_len), 32'(exp_len));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mux_sel", 32'(bus.mux_sel), 32'd3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ser_data", 32'(bus.ser_data), 32'd0);
    check("rst_par_bit", 32'(bus.par_bit), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-DATA aborts the frame immediately
    send(8'h3C, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_mux_sel", 32'(bus.mux_sel), 32'd3);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ser_data", 32'(bus.ser_data), 32'd0);
    check("midrst_par_bit", 32'(bus.par_bit), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Plain frame, no parity; also proves a clean restart after reset
    send(8'hA5, 1'b0, 1'b0);
    wait_idle(frame_len(1'b0));

    // Even and odd parity
    send(8'h03, 1'b1, 1'b0);
    wait_idle(frame_len(1'b1));
    send(8'h03, 1'b1, 1'b1);
    wait_idle(frame_len(1'b1));

    // Back-to-back with data_valid held high
    @(negedge clk);
    bus.p_data     = 8'hFF;
    bus.par_en     = 1'b1;
    bus.par_typ    = 1'b1;
    bus.data_valid = 1'b1;
    push_frame(8'hFF, 1'b1, 1'b1);
    push_frame(8'h00, 1'b1, 1'b1);
    $display("TX p_data=ff par_en=1 par_typ=1 (held valid)");
    @(posedge clk);
    @(negedge clk);
    bus.p_data = 8'h00;
    $display("TX p_data=00 par_en=1 par_typ=1 (held valid)");
    wait_level(1'b0, "b2b_first_end_timeout");
    check("b2b_first_len", 32'(last_len), 32'(frame_len(1'b1)));
    wait_level(1'b1, "b2b_second_start_timeout");
    check("b2b_idle_gap", 32'(last_gap), 32'd1);
    bus.data_valid = 1'b0;
    wait_idle(frame_len(1'b1));

    // Input changes during DATA do not affect the frame in flight
    send(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.p_data  = 8'hAA;
    bus.par_en  = 1'b1;
    bus.par_typ = 1'b1;
    wait_idle(frame_len(1'b0));

    // Stop-length frame (two stop cycles when the option is built)
    send(8'h5A, 1'b0, 1'b0);
    wait_idle(frame_len(1'b0));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_ctrl

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller and serializer for the UART transmitter; sits directly upstream of the TX output mux.
- Accepts a parallel byte on a valid strobe and walks the frame: start, data LSB-first, optional parity, stop.
- Drives the mux select, serial data bit and parity bit each cycle, plus a busy flag to the data source.
- One frame bit per clk cycle; clk is the baud-rate clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- clk  input  1  baud-rate clock, rising edge active.
- rst  input  1  asynchronous active-low reset.
- p_data  input  DATA_WIDTH  parallel word to transmit.
- data_valid  input  1  p_data valid; sampled only in IDLE.
- par_en  input  1  1 = parity bit inserted after data.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- mux_sel  output  2  frame-bit select: 00 start, 01 data, 10 parity, 11 stop/idle.
- ser_data  output  1  current data bit, LSB first.
- par_bit  output  1  parity of the latched word.
- busy  output  1  frame in progress; new requests ignored.

Behaviour:
- Reset (rst low, async), all registers cleared:
  - state=IDLE, mux_sel=11, busy=0, ser_data=0, par_bit=0.
  - Shift register, bit counter and latched par_en/par_typ are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns to idle-high after the mux's register.
- States: IDLE, START, DATA, PARITY, STOP. The state register is clocked; mux_sel and busy are decoded from state only (Moore, no glitch paths from inputs).
- IDLE:
  - mux_sel=11, busy=0.
  - If data_valid=1 at a rising edge: latch p_data into the shift register; latch par_en and par_typ; compute par_bit = ^p_data (even) or ~^p_data (odd); next state START.
- START: one cycle; mux_sel=00, busy=1. Next state is DATA with bit counter=0.
- DATA:
  - DATA_WIDTH cycles; mux_sel=01, busy=1.
  - ser_data = shift_reg[0]. The shift register shifts right each cycle and the counter increments.
  - When counter = DATA_WIDTH-1, next state is PARITY if latched par_en=1, else STOP.
- PARITY: one cycle; mux_sel=10, busy=1. par_bit is held stable for the whole frame. Next state STOP.
- STOP: one cycle; mux_sel=11, busy=1. Next state IDLE.
- Latency: data_valid sampled at edge k → mux_sel=00 during cycle k+1. The downstream mux adds one register stage, so the start bit appears on the line from edge k+2.
- Frame length in cycles (busy high) = 1 + DATA_WIDTH + par_en + 1. Minimum spacing between accepted words is that length plus 1 IDLE cycle.
- data_valid while busy=1 is ignored; no queuing, no error flag. The source must hold data_valid until it sees busy=1 or drop it.
- Changes to p_data, par_en or par_typ during a frame have no effect on the frame in flight.
- ser_data outside DATA: holds the last shifted value; don't-care to the mux. par_bit is updated only on acceptance.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: STOP lasts two cycles (mux_sel=11, busy=1 both), and frame length grows by 1. A sub-counter or extra STOP2 state is permitted.
- Undefined: single stop cycle exactly as above; no extra logic synthesized.

Test Plan:
- Reset mid-DATA, then release → mux_sel=11, busy=0 within the reset assertion. The next data_valid starts a clean frame with bit counter=0.
- p_data=8'hA5, par_en=0, data_valid pulse 1 cycle:
  - Next cycle mux_sel=00, then 8 cycles mux_sel=01 with ser_data=1,0,1,0,0,1,0,1, then 1 cycle mux_sel=11.
  - busy high exactly 10 cycles.
- p_data=8'h03, par_en=1, par_typ=0 → par_bit=0. PARITY cycle with mux_sel=10 follows the 8th data bit; busy high 11 cycles. Repeat with par_typ=1 → par_bit=1.
- Frame with p_data=8'hFF, par_en=1, par_typ=1, then p_data=8'h00 and data_valid held high throughout:
  - Second word is not accepted until IDLE.
  - Second frame's ser_data is all 0 and par_bit=1 (odd parity of 00).
  - Exactly 1 IDLE cycle separates the frames.
- Change p_data from 8'h55 to 8'hAA and par_en from 0 to 1 during DATA → transmitted bits remain those of 8'h55 and no PARITY state occurs.
- With UART_TX_STOP2_EN defined, p_data=8'h5A, par_en=0 → mux_sel=11 for 2 cycles after the data bits; busy high 11 cycles.
